pc_stack_seq: RTL and testbench

//  Next-generation program counter for the 8-bit core's fetch stage. Parametrised
//  PC width, data-path width and return-address stack. Supports sequential

---
 rtl/pc_stack_seq_if.sv | 33 +++
 rtl/pc_stack_seq.sv | 101 ++++++++++
 tb/tb_pc_stack_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_seq_if.sv
// Decoder-to-fetch control bundle for the PC / return-stack block.
// The master drives jump/call/stall requests; the slave returns PC and stack status.
interface pc_stack_seq_if #(
   parameter int D     = 12,
   parameter int W     = 8,
   parameter int DEPTH = 4
);
   localparam int SPW = $clog2(DEPTH + 1);

   logic           stall;
   logic           reljump_en;
   logic           absjump_en;
   logic           call_en;
   logic           ret_en;
   logic [D-1:0]   target;
   logic [W-1:0]   inB;
   logic [D-1:0]   prog_ctr;
   logic [SPW-1:0] sp;
   logic           stack_full;
   logic           stack_empty;
   logic           ovf_err;
   logic           unf_err;

   modport master (
      output stall, reljump_en, absjump_en, call_en, ret_en, target, inB,
      input  prog_ctr, sp, stack_full, stack_empty, ovf_err, unf_err
   );

   modport slave (
      input  stall, reljump_en, absjump_en, call_en, ret_en, target, inB,
      output prog_ctr, sp, stack_full, stack_empty, ovf_err, unf_err
   );
endinterface

// File: rtl/pc_stack_seq.sv
// Fetch-stage PC with return-address stack; a request in cycle N shows on prog_ctr in N+1.
// Stall freezes PC, stack pointer, stack and error flags; synchronous reset overrides everything.
module pc_stack_seq #(
   parameter int           D      = 12,
   parameter int           W      = 8,
   parameter int           DEPTH  = 4,
   parameter logic [D-1:0] RST_PC = {D{1'b1}}
) (
   input  logic          i_clk,
   input  logic          i_reset,
   pc_stack_seq_if.slave bus
);
   localparam int SPW = $clog2(DEPTH + 1);
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [D-1:0]   r_pc;
   logic [SPW-1:0] r_sp;
   logic [D-1:0]   r_stack [DEPTH];
   logic           r_ovf;
   logic           r_unf;

   logic [D-1:0]   w_pc_inc;
   logic [D-1:0]   w_abs;
   logic [SPW-1:0] w_sp_m1;
   logic           w_full;
   logic           w_empty;
   logic [D-1:0]   w_pc_nxt;
   logic [SPW-1:0] w_sp_nxt;
   logic           w_push;
   logic           w_ovf_set;
   logic           w_unf_set;

   assign w_pc_inc = r_pc + D'(1);
   // Size cast zero-extends when D > W and truncates otherwise.
   assign w_abs    = D'(bus.inB);
   assign w_sp_m1  = r_sp - SPW'(1);
   assign w_full   = (r_sp == SPW'(DEPTH));
   assign w_empty  = (r_sp == '0);

   always_comb begin
      w_pc_nxt  = r_pc;
      w_sp_nxt  = r_sp;
      w_push    = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      if (!bus.stall) begin
         if (bus.ret_en) begin
            if (!w_empty) begin
               w_pc_nxt = r_stack[w_sp_m1[AW-1:0]];
               w_sp_nxt = w_sp_m1;
            end else begin
               w_pc_nxt  = w_pc_inc;
               w_unf_set = 1'b1;
            end
         end else if (bus.call_en) begin
            // The jump is taken even when the push has to be dropped.
            w_pc_nxt = w_abs;
            if (!w_full) begin
               w_push   = 1'b1;
               w_sp_nxt = r_sp + SPW'(1);
            end else begin
               w_ovf_set = 1'b1;
            end
         end else if (bus.absjump_en) begin
            w_pc_nxt = w_abs;
         end else if (bus.reljump_en) begin
            w_pc_nxt = r_pc + bus.target;
         end else begin
            w_pc_nxt = w_pc_inc;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc  <= RST_PC;
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_pc  <= w_pc_nxt;
         r_sp  <= w_sp_nxt;
         r_ovf <= r_ovf | w_ovf_set;
         r_unf <= r_unf | w_unf_set;
      end
   end

   // Stack contents need no reset; only sp defines which entries are valid.
   always_ff @(posedge i_clk) begin
      if (!i_reset && w_push) begin
         r_stack[r_sp[AW-1:0]] <= w_pc_inc;
      end
   end

   assign bus.prog_ctr    = r_pc;
   assign bus.sp          = r_sp;
   assign bus.stack_full  = w_full;
   assign bus.stack_empty = w_empty;
   assign bus.ovf_err     = r_ovf;
   assign bus.unf_err     = r_unf;
endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed scenarios plus randomized traffic for pc_stack_seq, checked against a queue-based model.
module tb_pc_stack_seq;
   localparam int D     = 12;
   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int MASK  = (1 << D) - 1;
   localparam int RSTPC = MASK;

   logic clk;
   logic rst;

   pc_stack_seq_if #(.D(D), .W(W), .DEPTH(DEPTH)) bus ();

   pc_stack_seq #(.D(D), .W(W), .DEPTH(DEPTH)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   int m_pc;
   int m_q[$];
   bit m_ovf;
   bit m_unf;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic idle();
      bus.stall      = 1'b0;
      bus.reljump_en = 1'b0;
      bus.absjump_en = 1'b0;
      bus.call_en    = 1'b0;
      bus.ret_en     = 1'b0;
      bus.target     = '0;
      bus.inB        = '0;
   endtask

   // Reference behaviour: PC as an integer mod 2^D, stack as a LIFO queue.
   task automatic model_step();
      int t;
      if (rst) begin
         m_pc = RSTPC;
         m_q.delete();
         m_ovf = 0;
         m_unf = 0;
      end else if (bus.stall) begin
         m_pc = m_pc;
      end else if (bus.ret_en) begin
         if (m_q.size() > 0) m_pc = m_q.pop_back();
         else begin
            m_pc  = (m_pc + 1) & MASK;
            m_unf = 1;
         end
      end else if (bus.call_en) begin
         if (m_q.size() < DEPTH) m_q.push_back((m_pc + 1) & MASK);
         else m_ovf = 1;
         m_pc = int'(bus.inB);
      end else if (bus.absjump_en) begin
         m_pc = int'(bus.inB);
      end else if (bus.reljump_en) begin
         t = int'(bus.target);
         if (bus.target[D-1]) t = t - (1 << D);
         m_pc = (m_pc + t) & MASK;
      end else begin
         m_pc = (m_pc + 1) & MASK;
      end
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      chk({tag, ".pc"},    int'(bus.prog_ctr),    m_pc);
      chk({tag, ".sp"},    int'(bus.sp),          m_q.size());
      chk({tag, ".full"},  int'(bus.stack_full),  int'(m_q.size() == DEPTH));
      chk({tag, ".empty"}, int'(bus.stack_empty), int'(m_q.size() == 0));
      chk({tag, ".ovf"},   int'(bus.ovf_err),     int'(m_ovf));
      chk({tag, ".unf"},   int'(bus.unf_err),     int'(m_unf));
   endtask

   task automatic do_abs(input int a);
      idle(); bus.absjump_en = 1'b1; bus.inB = W'(a); cycle("abs"); idle();
   endtask

   task automatic do_call(input int a);
      idle(); bus.call_en = 1'b1; bus.inB = W'(a); cycle("call"); idle();
   endtask

   task automatic do_ret();
      idle(); bus.ret_en = 1'b1; cycle("ret"); idle();
   endtask

   task automatic do_rel(input int t);
      idle(); bus.reljump_en = 1'b1; bus.target = D'(t); cycle("rel"); idle();
   endtask

   int ret_exp[4] = '{'h053, 'h052, 'h051, 'h022};

   initial begin
      m_pc = 0; m_ovf = 0; m_unf = 0;
      idle();
      rst = 1'b1;
      #1;

      // Reset and first fetches
      cycle("rst0");
      chk("rst_pc", int'(bus.prog_ctr), 'hFFF);
      cycle("rst1");
      rst = 1'b0;
      cycle("inc0"); chk("first_fetch", int'(bus.prog_ctr), 'h000);
      cycle("inc1"); chk("fetch1", int'(bus.prog_ctr), 'h001);
      cycle("inc2"); chk("fetch2", int'(bus.prog_ctr), 'h002);

      // Relative jumps, backward and wrapping forward
      do_abs('h10);
      do_rel('hFFE); chk("rel_back", int'(bus.prog_ctr), 'h00E);
      do_rel('hFF0); chk("rel_neg_wrap", int'(bus.prog_ctr), 'hFFE);
      do_rel('h005); chk("rel_fwd_wrap", int'(bus.prog_ctr), 'h003);

      // Single call / return
      do_abs('h20);
      do_call('h40);
      chk("call_pc", int'(bus.prog_ctr), 'h040);
      chk("call_sp", int'(bus.sp), 1);
      for (int i = 0; i < 3; i++) cycle("sub_inc");
      do_ret();
      chk("ret_pc", int'(bus.prog_ctr), 'h021);
      chk("ret_sp", int'(bus.sp), 0);

      // Fill the stack, overflow, unwind, underflow
      for (int i = 0; i < 4; i++) do_call('h50 + i);
      chk("full_flag", int'(bus.stack_full), 1);
      do_call('h80);
      chk("ovf_pc", int'(bus.prog_ctr), 'h080);
      chk("ovf_sp", int'(bus.sp), 4);
      chk("ovf_err", int'(bus.ovf_err), 1);
      for (int i = 0; i < 4; i++) begin
         do_ret();
         chk("lifo_pc", int'(bus.prog_ctr), ret_exp[i]);
      end
      do_ret();
      chk("unf_pc", int'(bus.prog_ctr), 'h023);
      chk("unf_err", int'(bus.unf_err), 1);

      // Stall holds everything; simultaneous call+ret pops only
      do_abs('h30);
      do_call('h60);
      for (int i = 0; i < 3; i++) begin
         idle(); bus.stall = 1'b1; bus.absjump_en = 1'b1; bus.inB = 8'h99;
         cycle("stall");
         chk("stall_pc", int'(bus.prog_ctr), 'h060);
         chk("stall_sp", int'(bus.sp), 1);
      end
      idle(); bus.call_en = 1'b1; bus.ret_en = 1'b1; bus.inB = 8'h70;
      cycle("callret"); idle();
      chk("callret_pc", int'(bus.prog_ctr), 'h031);
      chk("callret_sp", int'(bus.sp), 0);

      // Reset beats stall and a pending call
      for (int i = 0; i < 3; i++) do_call('h10 * (i + 1));
      idle(); rst = 1'b1; bus.stall = 1'b1; bus.call_en = 1'b1; bus.inB = 8'h44;
      cycle("rst_mid");
      chk("rst_mid_pc", int'(bus.prog_ctr), 'hFFF);
      chk("rst_mid_sp", int'(bus.sp), 0);
      chk("rst_mid_ovf", int'(bus.ovf_err), 0);
      chk("rst_mid_unf", int'(bus.unf_err), 0);
      rst = 1'b0; idle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst            = ($urandom_range(199) == 0);
         bus.stall      = ($urandom_range(7) == 0);
         bus.ret_en     = ($urandom_range(4) == 0);
         bus.call_en    = ($urandom_range(3) == 0);
         bus.absjump_en = ($urandom_range(5) == 0);
         bus.reljump_en = ($urandom_range(3) == 0);
         bus.target     = D'($urandom);
         bus.inB        = W'($urandom);
         cycle("rand");
      end
      rst = 1'b0; idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
